muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the RV32M instructions in the pipelined core. It sits in the execute stage directly downstream of the register file: it takes the two register read operands plus the destination index, and computes the result over multiple cycles. It then produces a one-cycle write-back request (`done`, `rd_out`, `result`) that drives the register file's `reg_wr`, `waddr` and `wdata` through the write-back mux. `busy` stalls the front of the pipeline while an operation is in flight.

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency: done in cycle 34 after the start cycle (cycle 2 for divide-by-zero / signed overflow).
// Backpressure: busy stays high from cycle 1 until done; start is ignored while busy, and flush aborts to IDLE.
// Ports: clk/rst_n (async active-low); start/op/opa/opb/rd_in request; flush abort;
//        busy stall; done one-cycle write-back strobe with registered result/rd_out.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   a_q, a_d;       // multiplicand magnitude
    logic [XLEN-1:0]   b_q, b_d;       // divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;   // product, or {unused, dividend->quotient}
    logic [XLEN-1:0]   rem_q, rem_d;   // divide partial remainder
    logic              neg_q, neg_d;   // product / quotient must be negated
    logic              negr_q, negr_d; // remainder must be negated (dividend sign)
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    // Operand signs and magnitudes at request time.
    logic            a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;
    assign a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
    assign b_signed = a_signed && (op != 3'b010);
    assign sa       = a_signed && opa[XLEN-1];
    assign sb       = b_signed && opb[XLEN-1];
    assign mag_a    = sa ? -opa : opa;
    assign mag_b    = sb ? -opb : opb;
    assign div_zero = op[2] && (opb == '0);
    assign div_ovf  = op[2] && !op[0] && (opa == INT_MIN) && (opb == '1);

    // Multiply step: conditionally add multiplicand into the high half, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nx;
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
    assign mul_nx  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

    // Restoring divide step on a 33-bit partial remainder; the borrow bit of the
    // trial subtraction decides whether the quotient bit is 1.
    logic [XLEN:0]   rem_sh, rem_diff;
    logic            q_bit;
    assign rem_sh   = {rem_q, acc_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign q_bit    = !rem_diff[XLEN];

    // Sign correction and output selection.
    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quo_f, rem_f, fix_res;
    assign prod_f = neg_q  ? -acc_q : acc_q;
    assign quo_f  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_f  = negr_q ? -rem_q : rem_q;

    always_comb begin
        case (op_q)
            3'b000:                 fix_res = prod_f[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_f[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_f;
            default:                fix_res = rem_f;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        done_d   = 1'b0;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    rd_d   = rd_in;
                    cnt_d  = '0;
                    a_d    = mag_a;
                    b_d    = mag_b;
                    rem_d  = '0;
                    neg_d  = sa ^ sb;
                    negr_d = sa;
                    state_d = ST_CALC;
                    if (!op[2]) begin
                        acc_d = {{XLEN{1'b0}}, mag_b};
                    end else if (div_zero || div_ovf) begin
                        // Final quotient/remainder loaded directly; FIX passes them through.
                        acc_d   = {{XLEN{1'b0}}, div_zero ? {XLEN{1'b1}} : INT_MIN};
                        rem_d   = div_zero ? opa : '0;
                        neg_d   = 1'b0;
                        negr_d  = 1'b0;
                        state_d = ST_FIX;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, mag_a};
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (!op_q[2]) begin
                    acc_d = mul_nx;
                end else begin
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit};
                    rem_d = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = fix_res;
                rd_out_d = rd_q;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort wins over everything: no write-back, outputs keep their last values.
        if (flush) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            done_q   <= done_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations queued at issue, popped on done.
// Latency: checks done lands exactly 34 (or 2) cycles after the start cycle.
// Backpressure: waits on busy with a bounded cycle budget before each new issue.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
        string       tag;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    // Output monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            chk("done_gap", {31'b0, prev_done}, 32'd0);
            chk("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk({mon_e.tag, "_res"}, result, mon_e.res);
                chk({mon_e.tag, "_rd"}, {27'b0, rd_out}, {27'b0, mon_e.rd});
                chk({mon_e.tag, "_cyc"}, cyc, mon_e.cyc);
            end
        end
        prev_done = done;
    end

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sax = {{32{a[31]}}, a};
        logic [63:0] sbx = {{32{b[31]}}, b};
        logic [63:0] uax = {32'b0, a};
        logic [63:0] ubx = {32'b0, b};
        logic [63:0] p;
        int ia = a;
        int ib = b;
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'b000: begin p = sax * sbx; return p[31:0]; end
            3'b001: begin p = sax * sbx; return p[63:32]; end
            3'b010: begin p = sax * ubx; return p[63:32]; end
            3'b011: begin p = uax * ubx; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_rd  = 5'd0;

    // Wait (bounded) until the unit is back in IDLE; called at posedge+1.
    task automatic wait_idle(input string tag);
        for (int n = 0; n < 50 && busy; n++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    // Issue one operation at posedge+1; returns in the first IDLE cycle afterwards.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string tag);
        exp_t e;
        e.res = exp;
        e.rd  = rd;
        e.cyc = cyc + (is_special(o, a, b) ? 2 : 34);
        e.tag = tag;
        sb_q.push_back(e);
        op = o; opa = a; opb = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_idle(tag);
        last_res = exp;
        last_rd  = rd;
    endtask

    logic [2:0]  t_op [14] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101,
                               3'b111, 3'b100, 3'b111, 3'b100, 3'b110, 3'b101, 3'b110};
    logic [31:0] t_a  [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'd9, 32'hFFFF_FFF9};
    logic [31:0] t_b  [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] t_e  [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                               32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1;
        int s2;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op = 3'd0; opa = 32'd0; opb = 32'd0; rd_in = 5'd0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy",   {31'b0, busy}, 32'd0);
        chk("rst_done",   {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd",     {27'b0, rd_out}, 32'd0);

        // Directed cases including both special divide cases.
        for (int i = 0; i < 14; i++)
            issue(t_op[i], t_a[i], t_b[i], 5'(i + 1), t_e[i], $sformatf("dir%0d", i));

        // Random operations against the reference model.
        for (int i = 0; i < 10; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            issue(r_op, r_a, r_b, 5'($urandom_range(1, 31)), ref_op(r_op, r_a, r_b),
                  $sformatf("rnd%0d", i));
        end

        // Flush in cycle 10 of a DIV: no done, outputs untouched.
        op = 3'b100; opa = 32'd100; opb = 32'd7; rd_in = 5'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy",   {31'b0, busy}, 32'd0);
        chk("flush_result", result, last_res);
        chk("flush_rd",     {27'b0, rd_out}, {27'b0, last_rd});
        repeat (40) begin @(posedge clk); #1; end
        chk("flush_result_late", result, last_res);

        // Start pulsed in cycle 5 while busy is ignored.
        begin
            exp_t e;
            e.res = 32'd14; e.rd = 5'd3; e.cyc = cyc + 34; e.tag = "busy_start";
            sb_q.push_back(e);
            op = 3'b101; opa = 32'd100; opb = 32'd7; rd_in = 5'd3; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            op = 3'b000; opa = 32'd5; opb = 32'd5; rd_in = 5'd7; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            wait_idle("busy_start");
            @(posedge clk); #1;
            chk("busy_start_no_second", {31'b0, busy}, 32'd0);
            last_res = 32'd14; last_rd = 5'd3;
        end

        // Flush and start together in IDLE: request dropped.
        op = 3'b000; opa = 32'd6; opb = 32'd6; rd_in = 5'd11; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        chk("fs_busy", {31'b0, busy}, 32'd0);
        repeat (40) begin @(posedge clk); #1; end
        chk("fs_result", result, last_res);

        // Asynchronous reset in cycle 20 of a MUL.
        op = 3'b000; opa = 32'h1234; opb = 32'h10; rd_in = 5'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",   {31'b0, busy}, 32'd0);
        chk("arst_done",   {31'b0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_rd",     {27'b0, rd_out}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back MULs after reset, 35 cycles apart.
        s1 = cyc;
        issue(3'b000, 32'd3, 32'd4, 5'd1, 32'd12, "b2b0");
        s2 = cyc;
        issue(3'b000, 32'd3, 32'd4, 5'd2, 32'd12, "b2b1");
        chk("b2b_space", s2 - s1, 32'd35);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
